aes_round_key_engine: RTL and testbench
=======================================

AES_ROUND_KEY_ENGINE -- requirements
Module: aes_round_key_engine

Interface
REQ-001 The block SHALL have parameter NR, default 10, meaning the number of AES-128 rounds; legal range 1..10.
REQ-002 The block SHALL have parameter IDX_W, default 4, meaning the width of rk_index; IDX_W SHALL be at least ceil(log2(NR+1)).
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to begin a schedule run.
- dir  in  1  0 = forward from the cipher key; 1 = inverse from the round-NR key; sampled with start.
- key_in  in  [0:127]  seed key, sampled with start; bits [0:7] are byte 0; column-major words.
- busy  out  1  run in progress.
- rk_valid  out  1  rk_data holds a valid round key.
- rk_ready  in  1  consumer accepts rk_data.
- rk_data  out  [0:127]  round key, same byte and word order as key_in.
- rk_index  out  IDX_W  round number of rk_data.
- rk_last  out  1  rk_data is the final key of the run.
- done  out  1  one-cycle pulse ending a run.

Function
REQ-004 The FSM SHALL have the states IDLE and RUN, with these transitions:
- IDLE -> RUN when start=1.
- RUN -> IDLE on the handshake (rk_valid && rk_ready) of the key with rk_last=1.
REQ-005 start SHALL be accepted only in IDLE; start in RUN SHALL be ignored and the run SHALL not be disturbed.
REQ-006 On accept, the block SHALL in the next cycle present rk_valid=1 with rk_data=key_in, where rk_index=0 if dir=0 and rk_index=NR if dir=1.
REQ-007 Each handshake SHALL advance the output register in the following cycle:
- dir=0: rk_index+1, next key per the FIPS-197 forward expansion.
- dir=1: rk_index-1, previous key per the inverse expansion.
REQ-008 Forward step: temp = SubWord(RotWord(w3)) xor Rcon(i); w0' = w0^temp, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
REQ-009 Inverse step: w3p = w3^w2, w2p = w2^w1, w1p = w1^w0, w0p = w0 ^ SubWord(RotWord(w3p)) ^ Rcon(i), where i is the round being left; SubWord SHALL use the forward S-box.
REQ-010 Rcon SHALL be generated internally as {rc,24'h0}:
- forward: rc starts at 8'h01 and is multiplied by x (xtime, 0x1b reduction) per step.
- inverse: rc starts at Rcon(NR) and is divided by x per step (rc[0]=1: ((rc^8'h1b)>>1)|8'h80; else rc>>1).
REQ-011 The block SHALL deliver exactly NR+1 keys per run, one per cycle while rk_ready=1.
REQ-012 rk_last SHALL be 1 only with rk_index=NR (dir=0) or rk_index=0 (dir=1).
REQ-013 Backpressure: while rk_valid=1 and rk_ready=0, rk_data, rk_index and rk_last SHALL hold stable.
REQ-014 busy SHALL equal (state==RUN).
REQ-015 done SHALL pulse high in the cycle following the rk_last handshake; in that cycle rk_valid=0, and a new start SHALL be accepted in the same cycle.

Reset
REQ-016 When rst=1 at a clock edge, the block SHALL enter IDLE and set rk_valid=0, busy=0, done=0, rk_last=0, rk_index=0, rk_data=0 and the Rcon register to 0.
REQ-017 rst SHALL take priority over start and handshakes; reset mid-run SHALL abort the run with no done pulse.

Configuration
REQ-018 With macro AES_KEYGEN_INVMIX_EN defined, when dir=1 the block SHALL output InvMixColumns(key) for rk_index 1..NR-1, with rk_index NR and 0 output raw, for equivalent-inverse-cipher use; dir=0 SHALL be unaffected.
REQ-019 Under AES_KEYGEN_INVMIX_EN, the internal schedule state SHALL remain raw, and latency and handshake timing SHALL be identical to the build without it.
REQ-020 Without AES_KEYGEN_INVMIX_EN, the block SHALL contain no InvMixColumns logic and all keys SHALL be output raw.

Verification
REQ-021 Forward run: dir=0, key_in=2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> index 0 equals key_in, index 1 = a0fafe1788542cb123a339392a6c7605, index 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1, done pulses 12 cycles after start.
REQ-022 Inverse run: dir=1, key_in=d014f9a8c9ee2589e13f0cc8b6630ca6 -> index 9 = ac7766f319fadc2128d12941575c006e, index 0 = 2b7e151628aed2a6abf7158809cf4f3c with rk_last=1 (macro undefined).
REQ-023 Backpressure: rk_ready toggled in a pseudo-random pattern during REQ-021 -> identical key sequence, rk_data stable while stalled, exactly 11 handshakes.
REQ-024 Abuse: start=1 with dir=1 mid-run -> run continues unchanged; rst=1 at index 5 -> next cycle rk_valid=0, busy=0, and no done pulse.
REQ-025 Macro defined: REQ-022 stimulus -> index 10 and index 0 raw, index 9 = InvMixColumns(ac7766f319fadc2128d12941575c006e); REQ-021 outputs unchanged.

Source files
------------

// File: rtl/aes_round_key_engine.sv
// AES-128 round-key engine: streams the forward or inverse key schedule, one round key per handshake.
// Optional macro AES_KEYGEN_INVMIX_EN: inverse runs emit InvMixColumns of keys 1..NR-1 (equivalent inverse cipher).
module aes_round_key_engine #(
  parameter int NR    = 10,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [0:127]     key_in,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [0:127]     rk_data,
  output logic [IDX_W-1:0] rk_index,
  output logic             rk_last,
  output logic             done
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [2047:0] SBOX = {
    256'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] div_x(input logic [7:0] b);
    return b[0] ? {1'b1, b[7:1] ^ 7'h0d} : {1'b0, b[7:1]};
  endfunction

  // Byte 0 of the table sits in the top bits, so entry b starts at bit 2047-8b.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] fwd_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h000000};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot(w3) ^ {rc, 24'h000000};
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [7:0] rcon_at(input int n);
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 1; i < n; i++) begin
      rc = xtime(rc);
    end
    return rc;
  endfunction

  localparam logic [7:0]       RCON_NR  = rcon_at(NR);
  localparam logic [IDX_W-1:0] IDX_NR   = IDX_W'(NR);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  logic [127:0]     key_r, key_s;
  logic [7:0]       rcon_r, rcon_s;
  logic             dir_r, dir_s;
  logic             valid_r, valid_s;
  logic             last_r, last_s;
  logic [IDX_W-1:0] index_r, index_s;
  logic             done_r, done_s;
  logic             hs_s;

  // Next state: accept in IDLE, step the schedule on each handshake in RUN
  always_comb begin
    state_s = state_r;
    key_s   = key_r;
    rcon_s  = rcon_r;
    dir_s   = dir_r;
    valid_s = valid_r;
    last_s  = last_r;
    index_s = index_r;
    done_s  = 1'b0;
    hs_s    = valid_r & rk_ready;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
          key_s   = key_in;
          dir_s   = dir;
          valid_s = 1'b1;
          last_s  = 1'b0;
          index_s = dir ? IDX_NR : IDX_ZERO;
          rcon_s  = dir ? RCON_NR : 8'h01;
        end else begin
          valid_s = 1'b0;
          last_s  = 1'b0;
        end
      end
      RUN: begin
        if (hs_s && last_r) begin
          state_s = IDLE;
          valid_s = 1'b0;
          last_s  = 1'b0;
          done_s  = 1'b1;
        end else if (hs_s) begin
          if (dir_r) begin
            key_s   = inv_step(key_r, rcon_r);
            rcon_s  = div_x(rcon_r);
            index_s = index_r - IDX_ONE;
            last_s  = (index_r == IDX_ONE);
          end else begin
            key_s   = fwd_step(key_r, rcon_r);
            rcon_s  = xtime(rcon_r);
            index_s = index_r + IDX_ONE;
            last_s  = (index_r == (IDX_NR - IDX_ONE));
          end
        end else begin
          valid_s = valid_r;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
      end
    endcase
  end

  // State and schedule registers; rst overrides start and handshakes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      key_r   <= 128'h0;
      rcon_r  <= 8'h00;
      dir_r   <= 1'b0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      index_r <= IDX_ZERO;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      key_r   <= key_s;
      rcon_r  <= rcon_s;
      dir_r   <= dir_s;
      valid_r <= valid_s;
      last_r  <= last_s;
      index_r <= index_s;
      done_r  <= done_s;
    end
  end

`ifdef AES_KEYGEN_INVMIX_EN
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]   = c[31-8*i -: 8];
      x2     = xtime(a[i]);
      x4     = xtime(x2);
      x8     = xtime(x4);
      m9[i]  = x8 ^ a[i];
      m11[i] = x8 ^ x2 ^ a[i];
      m13[i] = x8 ^ x4 ^ a[i];
      m14[i] = x8 ^ x4 ^ x2;
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction

  logic [127:0] out_r, out_s;

  // Output view of the raw schedule; middle inverse keys go through InvMixColumns
  always_comb begin
    out_s = key_s;
    if (dir_s && (index_s != IDX_ZERO) && (index_s != IDX_NR)) begin
      out_s = {inv_mix_col(key_s[127:96]), inv_mix_col(key_s[95:64]),
               inv_mix_col(key_s[63:32]),  inv_mix_col(key_s[31:0])};
    end else begin
      out_s = key_s;
    end
  end

  // Output key register, updated in lockstep with the raw schedule
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r <= 128'h0;
    end else begin
      out_r <= out_s;
    end
  end

  assign rk_data = out_r;
`else
  assign rk_data = key_r;
`endif

  assign busy     = (state_r == RUN);
  assign rk_valid = valid_r;
  assign rk_index = index_r;
  assign rk_last  = last_r;
  assign done     = done_r;

endmodule

// File: tb/tb_aes_round_key_engine.sv
// Self-checking bench for aes_round_key_engine: known-answer table, backpressure, abuse and random runs
// against a reference key expansion computed from GF(2^8) arithmetic.
module tb_aes_round_key_engine;
  localparam int NR    = 10;
  localparam int IDX_W = 4;
  localparam int MAXK  = 32;

  logic             clk, rst, start, dir, rk_ready;
  logic [127:0]     key_in;
  logic             busy, rk_valid, rk_last, done;
  logic [127:0]     rk_data;
  logic [IDX_W-1:0] rk_index;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb [256];
  logic [127:0] rk_model [NR+1];
  logic [127:0] got_key [MAXK];
  int           got_idx [MAXK];
  logic         got_last [MAXK];
  int           n_hs, hs_cyc, done_cyc;

  typedef struct {
    logic         d;
    logic [127:0] key;
    int           idx;
    logic [127:0] exp;
  } kvec_t;
  kvec_t kv [7];

  aes_round_key_engine #(.NR(NR), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .key_in(key_in),
    .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
    .rk_index(rk_index), .rk_last(rk_last), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse (x^254) then the affine map.
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv, r, s;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    r = inv; s = inv;
    for (int i = 0; i < 4; i++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [127:0] invmix_ref(input logic [127:0] k);
    logic [7:0]   coef [4];
    logic [7:0]   a [4];
    logic [7:0]   r;
    logic [127:0] o;
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) a[i] = k[127-32*c-8*i -: 8];
      for (int row = 0; row < 4; row++) begin
        r = 8'h00;
        for (int i = 0; i < 4; i++) r = r ^ gmul(a[i], coef[(i - row + 4) % 4]);
        o[127-32*c-8*row -: 8] = r;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] adjust(input logic d, input int idx, input logic [127:0] raw);
`ifdef AES_KEYGEN_INVMIX_EN
    if (d && idx != 0 && idx != NR) return invmix_ref(raw);
`endif
    return raw;
  endfunction

  // FIPS-197 word-array expansion into rk_model[0..NR].
  task automatic expand(input logic [127:0] key);
    logic [31:0] w [4*(NR+1)];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4*(NR+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rk_model[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One schedule run; records every handshaken key and checks stall stability cycle by cycle.
  task automatic run_sched(input logic d, input logic [127:0] k, input bit bp, input bit poke,
                           input bit pre, input bit chain, input logic cd, input logic [127:0] ck);
    bit stalled, fin;
    logic [127:0] pdata;
    logic [IDX_W-1:0] pidx;
    logic plast;
    n_hs = 0; hs_cyc = -1; done_cyc = -1; stalled = 0; fin = 0;
    pdata = 128'h0; pidx = '0; plast = 1'b0;
    if (!pre) begin
      @(negedge clk);
      start = 1'b1; dir = d; key_in = k; rk_ready = 1'b1;
    end
    for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
      @(negedge clk);
      start = 1'b0; dir = d; key_in = k;
      if (poke && cyc == 4) begin
        start = 1'b1; dir = ~d; key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (done) begin
        fin = 1; done_cyc = cyc;
        check("done_valid", rk_valid, 128'd0);
        check("done_busy", busy, 128'd0);
        if (chain) begin
          start = 1'b1; dir = cd; key_in = ck;
        end
      end else begin
        check("run_busy", busy, 128'd1);
        check("run_valid", rk_valid, 128'd1);
        if (stalled) begin
          check("stall_data", rk_data, pdata);
          check("stall_idx", rk_index, pidx);
          check("stall_last", rk_last, plast);
        end
        rk_ready = bp ? 1'($urandom_range(1, 0)) : 1'b1;
        if (rk_valid && rk_ready) begin
          if (n_hs < MAXK) begin
            got_key[n_hs] = rk_data; got_idx[n_hs] = int'(rk_index); got_last[n_hs] = rk_last;
          end
          n_hs++; hs_cyc = cyc;
        end
        stalled = rk_valid && !rk_ready;
        pdata = rk_data; pidx = rk_index; plast = rk_last;
      end
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL run_timeout: got no done after 400 cycles, required a done pulse");
    end else if (!chain) begin
      @(negedge clk);
      check("done_one_cycle", done, 128'd0);
      check("idle_busy", busy, 128'd0);
    end
  endtask

  task automatic verify_run(input logic d, input string tag, input bit bp);
    int ei;
    check({tag, "_handshakes"}, n_hs, NR + 1);
    for (int i = 0; i < n_hs && i < MAXK && i <= NR; i++) begin
      ei = d ? NR - i : i;
      check($sformatf("%s_idx%0d", tag, i), got_idx[i], ei);
      check($sformatf("%s_key%0d", tag, i), got_key[i], adjust(d, ei, rk_model[ei]));
      check($sformatf("%s_last%0d", tag, i), got_last[i], (i == NR));
    end
    check({tag, "_done_after_last"}, done_cyc, hs_cyc + 1);
    if (!bp) check({tag, "_done_latency"}, done_cyc, NR + 2);
  endtask

  initial begin
    logic [127:0] k;
    logic d;
    bit bp, found;
    int cnt;
    rst = 1'b1; start = 1'b0; dir = 1'b0; key_in = 128'h0; rk_ready = 1'b0;
    for (int i = 0; i < 256; i++) sb[i] = sbox_ref(8'(i));
    kv[0] = '{1'b0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    kv[1] = '{1'b0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    kv[2] = '{1'b0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 2,  128'hf2c295f27a96b9435935807a7359f67f};
    kv[3] = '{1'b0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    kv[4] = '{1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    kv[5] = '{1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 9,  128'hac7766f319fadc2128d12941575c006e};
    kv[6] = '{1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", rk_valid, 128'd0);
    check("rst_busy", busy, 128'd0);
    check("rst_done", done, 128'd0);
    check("rst_last", rk_last, 128'd0);
    check("rst_index", rk_index, 128'd0);
    check("rst_data", rk_data, 128'd0);
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      run_sched(kv[v].d, kv[v].key, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 128'h0);
      found = 0;
      for (int j = 0; j < n_hs && j < MAXK; j++) begin
        if (got_idx[j] == kv[v].idx) begin
          found = 1;
          check($sformatf("kvec%0d_key", v), got_key[j], adjust(kv[v].d, kv[v].idx, kv[v].exp));
          check($sformatf("kvec%0d_last", v), got_last[j], (kv[v].idx == (kv[v].d ? 0 : NR)));
        end
      end
      check($sformatf("kvec%0d_found", v), found, 128'd1);
      check($sformatf("kvec%0d_done_latency", v), done_cyc, NR + 2);
    end

    expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    run_sched(1'b0, rk_model[0], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 128'h0);
    verify_run(1'b0, "bp_fwd", 1'b1);
    run_sched(1'b1, rk_model[NR], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 128'h0);
    verify_run(1'b1, "bp_inv", 1'b1);
    run_sched(1'b0, rk_model[0], 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 128'h0);
    verify_run(1'b0, "poke_fwd", 1'b0);
    run_sched(1'b1, rk_model[NR], 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 128'h0);
    verify_run(1'b1, "poke_inv", 1'b0);

    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    expand(k);
    run_sched(1'b0, rk_model[0], 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, rk_model[NR]);
    verify_run(1'b0, "chain_fwd", 1'b0);
    run_sched(1'b1, rk_model[NR], 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 128'h0);
    verify_run(1'b1, "chain_inv", 1'b0);

    for (int r = 0; r < 8; r++) begin
      k  = {$urandom(), $urandom(), $urandom(), $urandom()};
      d  = 1'($urandom_range(1, 0));
      bp = 1'($urandom_range(1, 0));
      expand(k);
      run_sched(d, d ? rk_model[NR] : rk_model[0], bp, 1'b0, 1'b0, 1'b0, 1'b0, 128'h0);
      verify_run(d, $sformatf("rand%0d", r), bp);
    end

    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    expand(k);
    @(negedge clk);
    start = 1'b1; dir = 1'b0; key_in = k; rk_ready = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cnt++;
    end while (!(rk_valid && rk_index == IDX_W'(5)) && cnt < 50);
    check("rstmid_reached_idx5", (cnt < 50), 128'd1);
    check("rstmid_key5", rk_data, rk_model[5]);
    rst = 1'b1; start = 1'b1; dir = 1'b1;
    @(negedge clk);
    check("rstmid_valid", rk_valid, 128'd0);
    check("rstmid_busy", busy, 128'd0);
    check("rstmid_done", done, 128'd0);
    check("rstmid_index", rk_index, 128'd0);
    check("rstmid_data", rk_data, 128'd0);
    check("rstmid_last", rk_last, 128'd0);
    rst = 1'b0; start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rstmid_no_done", done, 128'd0);
      check("rstmid_stays_idle", busy, 128'd0);
      check("rstmid_no_valid", rk_valid, 128'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
